// File: rtl/sys_host_cmd_master_if.sv
// Command / UART byte / response bundle shared by the host command master and its environment.
interface sys_host_cmd_master_if #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned OUT_WIDTH = 16
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [1:0]           cmd_type;
  logic [3:0]           cmd_addr;
  logic [WIDTH-1:0]     cmd_wdata;
  logic [WIDTH-1:0]     cmd_op_a;
  logic [WIDTH-1:0]     cmd_op_b;
  logic [3:0]           cmd_alu_fun;
  logic [WIDTH-1:0]     TX_P_DATA;
  logic                 TX_D_VLD;
  logic                 tx_ready;
  logic [WIDTH-1:0]     RX_P_DATA;
  logic                 RX_D_VLD;
  logic [OUT_WIDTH-1:0] rsp_data;
  logic                 rsp_valid;
  logic                 rsp_err;
  logic                 rsp_unexp;
  logic                 busy;

  // Command master side
  modport master (
    input  cmd_valid, cmd_type, cmd_addr, cmd_wdata, cmd_op_a, cmd_op_b, cmd_alu_fun,
    input  tx_ready, RX_P_DATA, RX_D_VLD,
    output cmd_ready, TX_P_DATA, TX_D_VLD, rsp_data, rsp_valid, rsp_err, rsp_unexp, busy
  );

  // Requester / UART side
  modport slave (
    output cmd_valid, cmd_type, cmd_addr, cmd_wdata, cmd_op_a, cmd_op_b, cmd_alu_fun,
    output tx_ready, RX_P_DATA, RX_D_VLD,
    input  cmd_ready, TX_P_DATA, TX_D_VLD, rsp_data, rsp_valid, rsp_err, rsp_unexp, busy
  );
endinterface

// File: rtl/sys_host_cmd_master.sv
// Host-side sys_ctrl command initiator: serialises one command into an AA/BB/CC/DD frame on the
// UART TX byte interface and assembles the response bytes from UART RX into one result word.
module sys_host_cmd_master #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned OUT_WIDTH   = 16,
  parameter int unsigned GAP_CYC     = 2,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                  CLK_IN,
  input  logic                  RST_IN,
  sys_host_cmd_master_if.master bus
);

  localparam int unsigned GAP_LAST = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;
  localparam int unsigned GAP_W    = (GAP_LAST > 0) ? $clog2(GAP_LAST + 1) : 1;
  localparam int unsigned TO_LAST  = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
  localparam int unsigned TO_W     = (TO_LAST > 0) ? $clog2(TO_LAST + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_GAP,
    S_WAIT_RSP,
    S_DONE
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [1:0]           r_type;
  logic [3:0]           r_addr;
  logic [WIDTH-1:0]     r_wdata;
  logic [WIDTH-1:0]     r_op_a;
  logic [WIDTH-1:0]     r_op_b;
  logic [3:0]           r_fun;
  logic [1:0]           r_byte_idx, w_byte_idx_nxt;
  logic [1:0]           r_rx_idx, w_rx_idx_nxt;
  logic [GAP_W-1:0]     r_gap_cnt, w_gap_cnt_nxt;
  logic [TO_W-1:0]      r_to_cnt, w_to_cnt_nxt;
  logic [OUT_WIDTH-1:0] r_rsp_buf, w_rsp_buf_nxt;
  logic [WIDTH-1:0]     r_tx_data, w_tx_data_nxt;
  logic                 w_err_nxt;
  logic                 r_tx_vld;
  logic [OUT_WIDTH-1:0] r_rsp_data;
  logic                 r_rsp_valid;
  logic                 r_rsp_err;
  logic                 r_rsp_unexp;
  logic                 r_cmd_ready;
  logic                 r_busy;
  logic [1:0]           w_last_idx;
  logic [1:0]           w_rsp_len;
  logic                 w_accept;
  logic                 w_rx_last;
  logic [WIDTH-1:0]     w_byte_inc;
  logic [WIDTH-1:0]     w_byte_cur;
  logic [WIDTH-1:0]     w_byte_hdr;

  // Frame byte idx of a command, fields zero-extended to the byte width
  function automatic logic [WIDTH-1:0] frame_byte(
    input logic [1:0]       typ,
    input logic [1:0]       idx,
    input logic [3:0]       addr,
    input logic [WIDTH-1:0] wdata,
    input logic [WIDTH-1:0] op_a,
    input logic [WIDTH-1:0] op_b,
    input logic [3:0]       fun
  );
    logic [WIDTH-1:0] b;
    b = '0;
    case (idx)
      2'd0: begin
        case (typ)
          2'd0:    b = WIDTH'(8'hAA);
          2'd1:    b = WIDTH'(8'hBB);
          2'd2:    b = WIDTH'(8'hCC);
          default: b = WIDTH'(8'hDD);
        endcase
      end
      2'd1: begin
        case (typ)
          2'd2:    b = op_a;
          2'd3:    b = WIDTH'(fun);
          default: b = WIDTH'(addr);
        endcase
      end
      2'd2: begin
        case (typ)
          2'd0:    b = wdata;
          2'd2:    b = op_b;
          default: b = '0;
        endcase
      end
      default: b = (typ == 2'd2) ? WIDTH'(fun) : '0;
    endcase
    return b;
  endfunction

  // Frame length and response byte count of the captured command
  always_comb begin
    w_last_idx = 2'd1;
    w_rsp_len  = 2'd2;
    case (r_type)
      2'd0:    begin w_last_idx = 2'd2; w_rsp_len = 2'd0; end
      2'd1:    begin w_last_idx = 2'd1; w_rsp_len = 2'd1; end
      2'd2:    begin w_last_idx = 2'd3; w_rsp_len = 2'd2; end
      default: begin w_last_idx = 2'd1; w_rsp_len = 2'd2; end
    endcase
  end

  assign w_accept   = (r_state == S_IDLE) && bus.cmd_valid;
  assign w_rx_last  = bus.RX_D_VLD && ((r_rx_idx + 2'd1) == w_rsp_len);
  assign w_byte_inc = frame_byte(r_type, r_byte_idx + 2'd1, r_addr, r_wdata, r_op_a, r_op_b, r_fun);
  assign w_byte_cur = frame_byte(r_type, r_byte_idx, r_addr, r_wdata, r_op_a, r_op_b, r_fun);
  assign w_byte_hdr = frame_byte(bus.cmd_type, 2'd0, bus.cmd_addr, bus.cmd_wdata,
                                 bus.cmd_op_a, bus.cmd_op_b, bus.cmd_alu_fun);

  // Capture all command fields on acceptance so the requester may change them afterwards
  always_ff @(posedge CLK_IN or negedge RST_IN) begin
    if (!RST_IN) begin
      r_type  <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_fun   <= '0;
    end else if (w_accept) begin
      r_type  <= bus.cmd_type;
      r_addr  <= bus.cmd_addr;
      r_wdata <= bus.cmd_wdata;
      r_op_a  <= bus.cmd_op_a;
      r_op_b  <= bus.cmd_op_b;
      r_fun   <= bus.cmd_alu_fun;
    end
  end

  // Next-state, counters and next output values
  always_comb begin
    w_state_nxt    = r_state;
    w_byte_idx_nxt = r_byte_idx;
    w_rx_idx_nxt   = r_rx_idx;
    w_gap_cnt_nxt  = r_gap_cnt;
    w_to_cnt_nxt   = r_to_cnt;
    w_rsp_buf_nxt  = r_rsp_buf;
    w_tx_data_nxt  = r_tx_data;
    w_err_nxt      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          w_state_nxt    = S_SEND;
          w_byte_idx_nxt = 2'd0;
          w_rx_idx_nxt   = 2'd0;
          w_rsp_buf_nxt  = '0;
          w_tx_data_nxt  = w_byte_hdr;
        end
      end
      S_SEND: begin
        if (bus.tx_ready) begin
          if (r_byte_idx == w_last_idx) begin
            w_to_cnt_nxt = '0;
            w_state_nxt  = (w_rsp_len != 2'd0) ? S_WAIT_RSP : S_DONE;
          end else begin
            w_byte_idx_nxt = r_byte_idx + 2'd1;
            if (GAP_CYC > 0) begin
              w_state_nxt   = S_GAP;
              w_gap_cnt_nxt = '0;
            end else begin
              w_tx_data_nxt = w_byte_inc;
            end
          end
        end
      end
      S_GAP: begin
        if (r_gap_cnt == GAP_W'(GAP_LAST)) begin
          w_state_nxt   = S_SEND;
          w_tx_data_nxt = w_byte_cur;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt + GAP_W'(1);
        end
      end
      S_WAIT_RSP: begin
        w_to_cnt_nxt = r_to_cnt + TO_W'(1);
        if (bus.RX_D_VLD) begin
          if (r_rx_idx == 2'd0) w_rsp_buf_nxt[WIDTH-1:0] = bus.RX_P_DATA;
          else                  w_rsp_buf_nxt[2*WIDTH-1:WIDTH] = bus.RX_P_DATA;
          w_rx_idx_nxt = r_rx_idx + 2'd1;
        end
        if (w_rx_last) begin
          w_state_nxt = S_DONE;
        end else if (r_to_cnt == TO_W'(TO_LAST)) begin
          w_state_nxt = S_DONE;
          w_err_nxt   = 1'b1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register and registered outputs
  always_ff @(posedge CLK_IN or negedge RST_IN) begin
    if (!RST_IN) begin
      r_state     <= S_IDLE;
      r_byte_idx  <= '0;
      r_rx_idx    <= '0;
      r_gap_cnt   <= '0;
      r_to_cnt    <= '0;
      r_rsp_buf   <= '0;
      r_tx_data   <= '0;
      r_tx_vld    <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_unexp <= 1'b0;
      r_cmd_ready <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_byte_idx  <= w_byte_idx_nxt;
      r_rx_idx    <= w_rx_idx_nxt;
      r_gap_cnt   <= w_gap_cnt_nxt;
      r_to_cnt    <= w_to_cnt_nxt;
      r_rsp_buf   <= w_rsp_buf_nxt;
      r_tx_data   <= w_tx_data_nxt;
      r_tx_vld    <= (w_state_nxt == S_SEND);
      if (w_state_nxt == S_DONE) r_rsp_data <= w_rsp_buf_nxt;
      r_rsp_valid <= (w_state_nxt == S_DONE);
      r_rsp_err   <= w_err_nxt;
      r_rsp_unexp <= bus.RX_D_VLD && (r_state != S_WAIT_RSP);
      r_cmd_ready <= (w_state_nxt == S_IDLE);
      r_busy      <= (w_state_nxt != S_IDLE);
    end
  end

  assign bus.TX_P_DATA = r_tx_data;
  assign bus.TX_D_VLD  = r_tx_vld;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.rsp_unexp = r_rsp_unexp;
  assign bus.cmd_ready = r_cmd_ready;
  assign bus.busy      = r_busy;

endmodule
